nlc_lin_serializer: RTL and testbench

Downstream stage of the 16-channel NLC array. Captures all 16 corrected samples (chN_x_lin) on the NLC output-ready strobe into a double-buffered frame store. Streams them out one channel per beat over a valid/ready interface toward the readout/FIFO path. Detects and counts frames lost to back-pressure.

---
 rtl/nlc_pkg.sv | 12 +
 rtl/nlc_frame_bank.sv | 41 ++++
 rtl/nlc_lin_serializer.sv | 150 +++++++++++++++
 tb/tb_nlc_lin_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nlc_pkg.sv
// rtl/nlc_pkg.sv - shared NLC widths and sample/frame types
package nlc_pkg;

    localparam int DATA_W = 21;
    localparam int NUM_CH = 16;
    localparam int CH_W   = 4;
    localparam int CNT_W  = 8;

    typedef logic [DATA_W-1:0] x_lin_t;
    typedef x_lin_t [NUM_CH-1:0] frame_t;

endpackage

// File: rtl/nlc_frame_bank.sv
// rtl/nlc_frame_bank.sv - one frame of corrected samples with full flag and read mux
module nlc_frame_bank
#(
    parameter int DATA_W = 21,
    parameter int NUM_CH = 16,
    parameter int CH_W   = 4
)
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic                           free,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  frame_in,
    input  logic [CH_W-1:0]                rd_idx,
    output logic                           full,
    output logic [DATA_W-1:0]              rd_data
);

    logic [NUM_CH-1:0][DATA_W-1:0] data;

    // Full flag: a load on the same edge as a free keeps the bank occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (free) begin
            full <= 1'b0;
        end
    end

    // Sample storage: written only on an accepted capture, never reset.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= frame_in;
        end
    end

    assign rd_data = data[rd_idx];

endmodule

// File: rtl/nlc_lin_serializer.sv
// rtl/nlc_lin_serializer.sv - double-buffered capture of 16 NLC samples, streamed one channel per beat
module nlc_lin_serializer
#(
    parameter int DATA_W = 21,
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              srdy_lin_i,
    input  logic [DATA_W-1:0] ch0_x_lin,
    input  logic [DATA_W-1:0] ch1_x_lin,
    input  logic [DATA_W-1:0] ch2_x_lin,
    input  logic [DATA_W-1:0] ch3_x_lin,
    input  logic [DATA_W-1:0] ch4_x_lin,
    input  logic [DATA_W-1:0] ch5_x_lin,
    input  logic [DATA_W-1:0] ch6_x_lin,
    input  logic [DATA_W-1:0] ch7_x_lin,
    input  logic [DATA_W-1:0] ch8_x_lin,
    input  logic [DATA_W-1:0] ch9_x_lin,
    input  logic [DATA_W-1:0] ch10_x_lin,
    input  logic [DATA_W-1:0] ch11_x_lin,
    input  logic [DATA_W-1:0] ch12_x_lin,
    input  logic [DATA_W-1:0] ch13_x_lin,
    input  logic [DATA_W-1:0] ch14_x_lin,
    input  logic [DATA_W-1:0] ch15_x_lin,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_x_lin,
    output logic [3:0]        dout_ch,
    output logic              dout_last,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              clear_overflow
);

    import nlc_pkg::*;

    logic [NUM_CH-1:0][DATA_W-1:0] frame;
    logic [1:0]                    full;
    logic [1:0]                    load;
    logic [1:0]                    free;
    logic [DATA_W-1:0]             rd_data [2];
    logic                          wr_bank;
    logic                          rd_bank;
    logic [CH_W-1:0]               idx;
    logic                          xfer;
    logic                          last_beat;
    logic                          last_xfer;
    logic                          wr_avail;
    logic                          capture;
    logic                          drop;

    assign frame = {ch15_x_lin, ch14_x_lin, ch13_x_lin, ch12_x_lin,
                    ch11_x_lin, ch10_x_lin, ch9_x_lin,  ch8_x_lin,
                    ch7_x_lin,  ch6_x_lin,  ch5_x_lin,  ch4_x_lin,
                    ch3_x_lin,  ch2_x_lin,  ch1_x_lin,  ch0_x_lin};

    // The write bank is usable if empty, or if its final beat leaves on this very edge.
    assign last_beat = (idx == CH_W'(NUM_CH - 1));
    assign xfer      = dout_valid & dout_ready;
    assign last_xfer = xfer & last_beat;
    assign wr_avail  = ~full[wr_bank] | (last_xfer & (rd_bank == wr_bank));
    assign capture   = srdy_lin_i & wr_avail;
    assign drop      = srdy_lin_i & ~wr_avail;

    assign load[0] = capture & (wr_bank == 1'b0);
    assign load[1] = capture & (wr_bank == 1'b1);
    assign free[0] = last_xfer & (rd_bank == 1'b0);
    assign free[1] = last_xfer & (rd_bank == 1'b1);

    nlc_frame_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) u_bank_a (
        .clk      (clk),
        .reset    (reset),
        .load     (load[0]),
        .free     (free[0]),
        .frame_in (frame),
        .rd_idx   (idx),
        .full     (full[0]),
        .rd_data  (rd_data[0])
    );

    nlc_frame_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) u_bank_b (
        .clk      (clk),
        .reset    (reset),
        .load     (load[1]),
        .free     (free[1]),
        .frame_in (frame),
        .rd_idx   (idx),
        .full     (full[1]),
        .rd_data  (rd_data[1])
    );

    // Bank pointers and beat index advance only on accepted captures and transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            idx     <= '0;
        end else begin
            if (capture) begin
                wr_bank <= ~wr_bank;
            end
            if (xfer) begin
                if (last_beat) begin
                    idx     <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    idx <= idx + CH_W'(1);
                end
            end
        end
    end

    // Sticky overflow and saturating drop counter; a coincident drop beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else if (clear_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Output beat is a registered-bank mux, forced to zero while nothing is offered.
    always_comb begin
        dout_valid = full[rd_bank];
        dout_x_lin = '0;
        dout_ch    = '0;
        dout_last  = 1'b0;
        if (dout_valid) begin
            dout_x_lin = rd_data[rd_bank];
            dout_ch    = idx;
            dout_last  = last_beat;
        end
    end

    assign busy = full[0] | full[1];

endmodule

// File: tb/tb_nlc_lin_serializer.sv
// tb/tb_nlc_lin_serializer.sv - directed self-checking bench for nlc_lin_serializer
module tb_nlc_lin_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        srdy_lin_i;
    logic [20:0] chv [16];
    logic        dout_valid;
    logic        dout_ready;
    logic [20:0] dout_x_lin;
    logic [3:0]  dout_ch;
    logic        dout_last;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clear_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nlc_lin_serializer dut (
        .clk            (clk),
        .reset          (reset),
        .srdy_lin_i     (srdy_lin_i),
        .ch0_x_lin      (chv[0]),
        .ch1_x_lin      (chv[1]),
        .ch2_x_lin      (chv[2]),
        .ch3_x_lin      (chv[3]),
        .ch4_x_lin      (chv[4]),
        .ch5_x_lin      (chv[5]),
        .ch6_x_lin      (chv[6]),
        .ch7_x_lin      (chv[7]),
        .ch8_x_lin      (chv[8]),
        .ch9_x_lin      (chv[9]),
        .ch10_x_lin     (chv[10]),
        .ch11_x_lin     (chv[11]),
        .ch12_x_lin     (chv[12]),
        .ch13_x_lin     (chv[13]),
        .ch14_x_lin     (chv[14]),
        .ch15_x_lin     (chv[15]),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_x_lin     (dout_x_lin),
        .dout_ch        (dout_ch),
        .dout_last      (dout_last),
        .busy           (busy),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .clear_overflow (clear_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input int base);
        for (int n = 0; n < 16; n++) chv[n] = 21'(base + n);
    endtask

    task automatic strobe(input int base);
        set_frame(base);
        srdy_lin_i = 1'b1;
        tick();
        srdy_lin_i = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int exp_data, input int exp_ch);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
        chk({tag, "_data"},  32'(dout_x_lin), 32'(exp_data));
        chk({tag, "_ch"},    32'(dout_ch),    32'(exp_ch));
        chk({tag, "_last"},  32'(dout_last),  32'(exp_ch == 15));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_data"},  32'(dout_x_lin), 32'd0);
        chk({tag, "_ch"},    32'(dout_ch),    32'd0);
        chk({tag, "_last"},  32'(dout_last),  32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        srdy_lin_i     = 1'b0;
        dout_ready     = 1'b0;
        clear_overflow = 1'b0;
        set_frame(0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk_idle("rst");
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(drop_cnt), 32'd0);

        // 1. Single frame with ready held high
        dout_ready = 1'b1;
        strobe(32'h1000);
        for (int i = 0; i < 16; i++) begin
            chk_beat("t1", 32'h1000 + i, i);
            tick();
        end
        chk_idle("t1_end");

        // 2. Back-pressure: ready alternates 0/1, beat held while stalled
        dout_ready = 1'b0;
        strobe(32'h1000);
        for (int i = 0; i < 16; i++) begin
            dout_ready = 1'b0;
            chk_beat("t2_hold", 32'h1000 + i, i);
            tick();
            dout_ready = 1'b1;
            chk_beat("t2_xfer", 32'h1000 + i, i);
            tick();
        end
        chk_idle("t2_end");

        // 3. Back-to-back strobes: 32 beats without a bubble
        dout_ready = 1'b1;
        strobe(32'h2000);
        for (int k = 0; k < 32; k++) begin
            if (k == 0) begin
                set_frame(32'h3000);
                srdy_lin_i = 1'b1;
            end else begin
                srdy_lin_i = 1'b0;
            end
            chk_beat("t3", (k < 16) ? 32'h2000 + k : 32'h3000 + k - 16, k % 16);
            tick();
        end
        srdy_lin_i = 1'b0;
        chk_idle("t3_end");
        chk("t3_ovf", 32'(overflow), 32'd0);

        // 4. Overflow: third frame dropped, drop-vs-clear priority, saturation
        dout_ready = 1'b0;
        strobe(32'h5000);
        strobe(32'h6000);
        strobe(32'h7000);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_cnt", 32'(drop_cnt), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        clear_overflow = 1'b1;
        strobe(32'h7100);
        clear_overflow = 1'b0;
        chk("t4_clr_drop_ovf", 32'(overflow), 32'd1);
        chk("t4_clr_drop_cnt", 32'(drop_cnt), 32'd1);
        set_frame(32'h7200);
        srdy_lin_i = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        srdy_lin_i = 1'b0;
        chk("t4_sat", 32'(drop_cnt), 32'hFF);
        dout_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk_beat("t4_drain", (k < 16) ? 32'h5000 + k : 32'h6000 + k - 16, k % 16);
            tick();
        end
        chk_idle("t4_end");
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t4_cleared_ovf", 32'(overflow), 32'd0);
        chk("t4_cleared_cnt", 32'(drop_cnt), 32'd0);

        // 5. Free-and-fill: capture coincides with the last beat of the write bank
        dout_ready = 1'b0;
        strobe(32'h2100);
        strobe(32'h2200);
        dout_ready = 1'b1;
        for (int k = 0; k < 48; k++) begin
            if (k == 15) begin
                set_frame(32'h4000);
                srdy_lin_i = 1'b1;
            end else begin
                srdy_lin_i = 1'b0;
            end
            chk_beat("t5", (k < 16) ? 32'h2100 + k :
                           (k < 32) ? 32'h2200 + k - 16 : 32'h4000 + k - 32, k % 16);
            tick();
        end
        srdy_lin_i = 1'b0;
        chk_idle("t5_end");
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_cnt", 32'(drop_cnt), 32'd0);

        // 6. Reset mid-frame discards everything, next frame starts at ch0
        dout_ready = 1'b0;
        strobe(32'h1100);
        strobe(32'h1200);
        strobe(32'h1300);
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_beat("t6_pre", 32'h1100 + 8, 8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("t6_rst");
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_cnt", 32'(drop_cnt), 32'd0);
        strobe(32'h8000);
        for (int i = 0; i < 16; i++) begin
            chk_beat("t6_new", 32'h8000 + i, i);
            tick();
        end
        chk_idle("t6_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
